// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding and default width.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    RUN  = S_RUN,
    DONE = S_DONE
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bundle for the serial subtractor.
interface serial_subtractor_if
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             b_in;
  logic [WIDTH-1:0] diff;
  logic             b_out;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b, b_in,
    input  diff, b_out, busy, done
  );

  modport slave (
    input  start, a, b, b_in,
    output diff, b_out, busy, done
  );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit combinational subtractor cell: d = x - y - bin with borrow-out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - b_in (mod 2^WIDTH), one bit per clock, LSB first.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave bus
);

  state_t             state;
  logic [WIDTH-1:0]   sh_a;
  logic [WIDTH-1:0]   sh_b;
  logic [WIDTH-1:0]   sh_d;
  logic               br;
  logic [CNT_W-1:0]   cnt;
  logic               d;
  logic               bout;

  full_subtractor u_cell (
    .x    (sh_a[0]),
    .y    (sh_b[0]),
    .bin  (br),
    .d    (d),
    .bout (bout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sh_a      <= '0;
      sh_b      <= '0;
      sh_d      <= '0;
      br        <= 1'b0;
      cnt       <= '0;
      bus.diff  <= '0;
      bus.b_out <= 1'b0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sh_a     <= bus.a;
            sh_b     <= bus.b;
            sh_d     <= '0;
            br       <= bus.b_in;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          sh_a <= sh_a >> 1;
          sh_b <= sh_b >> 1;
          sh_d <= {d, sh_d[WIDTH-1:1]};
          br   <= bout;
          // Final bit is folded straight into diff so the result lands on the same edge.
          if (cnt == CNT_W'(WIDTH - 1)) begin
            bus.diff  <= {d, sh_d[WIDTH-1:1]};
            bus.b_out <= bout;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b1;
            cnt       <= '0;
            state     <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor with a cycle-level handshake model and result scoreboard.
module tb_serial_subtractor;
  import serial_sub_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W), .CNT_W($clog2(W))) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int ph = 0;                 // 0 idle, 1..16 running, 17 done cycle
  logic [W:0] held = '0;      // {b_out, diff} the DUT must currently show
  logic [W:0] q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: predict acceptance, advance the model, then sample #1 after the edge.
  task automatic step();
    logic [W:0] e;
    logic acc;
    acc = !rst && ph == 0 && bus.start;
    if (acc) begin
      e = {1'b0, bus.a} - {1'b0, bus.b} - {{W{1'b0}}, bus.b_in};
      q.push_back(e);
    end
    @(posedge clk);
    if (rst) begin
      ph = 0;
      q.delete();
      held = '0;
    end else if (ph == 0) begin
      if (acc) ph = 1;
    end else if (ph == 17) begin
      ph = 0;
    end else begin
      ph++;
    end
    #1;
    if (ph == 17 && q.size() > 0) held = q.pop_front();
    check("busy", 32'(bus.busy), 32'(ph >= 1 && ph <= 16));
    check("done", 32'(bus.done), 32'(ph == 17));
    check("result_hold", 32'({bus.b_out, bus.diff}), 32'(held));
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    bus.a = a; bus.b = b; bus.b_in = bi; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.a = ~a; bus.b = ~b; bus.b_in = ~bi;
    for (int i = 0; i < 40 && ph != 0; i++) step();
    check("op_timeout", 32'(ph), 32'd0);
  endtask

  task automatic expect_res(input string tag, input logic [W-1:0] ed, input logic eb);
    check(tag, 32'({bus.b_out, bus.diff}), 32'({eb, ed}));
  endtask

  initial begin
    logic [W-1:0] sa, sb;
    logic sbi;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.b_in = 1'b0;

    // Reset state
    rst = 1'b1;
    step(); step();
    expect_res("reset_outputs", 16'h0000, 1'b0);
    check("reset_busy_done", 32'({bus.busy, bus.done}), 32'd0);
    rst = 1'b0;
    step();

    // Directed operations
    run_op(16'd5, 16'd3, 1'b0);
    expect_res("t1_5_minus_3", 16'd2, 1'b0);
    run_op(16'h0000, 16'h0001, 1'b0);
    expect_res("t2_wrap", 16'hFFFF, 1'b1);
    check("t2_adder_xcheck", 32'(W'(bus.diff + 16'h0001)), 32'h0000);
    run_op(16'h8000, 16'h7FFF, 1'b1);
    expect_res("t3_8000", 16'h0000, 1'b0);
    run_op(16'h1234, 16'h1234, 1'b1);
    expect_res("t3_equal_bin", 16'hFFFF, 1'b1);
    run_op(16'h0000, 16'hFFFF, 1'b1);
    expect_res("wrap_all_ones", 16'h0000, 1'b1);

    // Start held high with operands changing every cycle
    for (int i = 0; i < 40; i++) begin
      bus.start = 1'b1;
      bus.a = W'($urandom); bus.b = W'($urandom); bus.b_in = 1'($urandom);
      step();
    end
    bus.start = 1'b0;
    for (int i = 0; i < 40 && ph != 0; i++) step();
    check("t4_drain", 32'(ph), 32'd0);
    check("t4_queue_empty", 32'(q.size()), 32'd0);

    // Reset mid-run at cnt == 7
    bus.a = 16'hAAAA; bus.b = 16'h5555; bus.b_in = 1'b0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (7) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    expect_res("t5_abort_outputs", 16'h0000, 1'b0);
    check("t5_abort_busy_done", 32'({bus.busy, bus.done}), 32'd0);
    repeat (20) step();
    run_op(16'hAAAA, 16'h5555, 1'b0);
    expect_res("t5_fresh", 16'h5555, 1'b0);

    // Reset has priority over start on the same edge
    rst = 1'b1; bus.start = 1'b1; bus.a = 16'h0001; bus.b = 16'h0002; bus.b_in = 1'b0;
    step();
    rst = 1'b0; bus.start = 1'b0;
    check("rst_over_start", 32'(bus.busy), 32'd0);
    step();

    // Incrementing sweep
    sa = 16'hFFF0; sb = 16'h0003; sbi = 1'b0;
    for (int i = 0; i < 50; i++) begin
      run_op(sa, sb, sbi);
      sa = sa + 16'd1;
      if (i % 2 == 1) sb = sb + 16'd1;
      sbi = ~sbi;
    end
    check("final_queue_empty", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial multi-cycle subtractor, the inverse operation to the team's 16-bit combinational full adder.
- Computes diff = a - b - b_in modulo 2^WIDTH and a borrow-out, one bit per clock, LSB first.
- Sits beside the adder as a low-area arithmetic unit driven by a start/busy/done handshake.
- Results can be cross-checked against the adder: diff + b + b_in = a (mod 2^WIDTH).

Parameters:
- WIDTH, 16, operand and result width in bits (must be >= 2).
- CNT_W, $clog2(WIDTH), width of the internal bit counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepting edge.
- b  input  WIDTH  subtrahend; captured on the accepting edge.
- b_in  input  1  borrow-in; captured on the accepting edge.
- diff  output  WIDTH  registered result; held until the next result.
- b_out  output  1  registered borrow-out; 1 iff a < b + b_in (unsigned).
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when diff/b_out become valid.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state=IDLE.
  - diff=0, b_out=0, busy=0, done=0.
  - Shift registers, counter and borrow flop cleared.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge N:
  - Load sh_a<=a, sh_b<=b, br<=b_in, cnt<=0, busy<=1; go to RUN.
- IDLE, start=0: stay; outputs hold.
- RUN, each edge:
  - d = sh_a[0] ^ sh_b[0] ^ br.
  - br <= (~sh_a[0] & sh_b[0]) | (~(sh_a[0] ^ sh_b[0]) & br).
  - sh_a and sh_b shift right by 1.
  - d shifts into the MSB of the result shift register.
  - cnt <= cnt+1.
- RUN, edge where cnt == WIDTH-1 (last bit), which is edge N+WIDTH:
  - diff <= full shifted result, including the final bit.
  - b_out <= final borrow.
  - busy<=0, done<=1; go to DONE.
- DONE:
  - Lasts exactly one cycle: done=1 in the cycle after edge N+WIDTH.
  - Next edge: done<=0; go to IDLE.
- Latency: start accepted at edge N -> done high in the cycle following edge N+WIDTH.
  - Accept-to-accept period is WIDTH+2 cycles.
- start while RUN or DONE is ignored: no restart, no queueing, and operands are not re-captured.
- Operand inputs may change freely after the accepting edge.
- diff/b_out change only on the completing edge or on reset. They are stable during busy and from done until the next completion.
- Reset mid-RUN aborts: all outputs return to their reset values next cycle. No done pulse is produced for the aborted operation.
- Reset has priority over start on the same edge.
- Wrap-around:
  - Result is modulo 2^WIDTH.
  - a=0, b=2^WIDTH-1, b_in=1 gives diff=0, b_out=1.
- Counter never exceeds WIDTH-1; cnt is don't-care outside RUN but is held at 0.

Decomposition:
- Package serial_sub_pkg:
  - State encoding localparams S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2.
  - Default WIDTH=16.
- Sub-module full_subtractor:
  - 1-bit combinational cell with ports x, y, bin -> d, bout, implementing the equations above.
  - Instantiated once and fed from the shift-register LSBs. It is the bit-level mirror of the adder cell.

Test Plan:
1. a=16'd5, b=16'd3, b_in=0, start pulse -> busy for 16 cycles; done one cycle; diff=16'd2, b_out=0.
2. a=16'h0000, b=16'h0001, b_in=0 -> diff=16'hFFFF, b_out=1; adder check 0xFFFF+1+0 = 0x0000.
3. a=16'h8000, b=16'h7FFF, b_in=1 -> diff=16'h0000, b_out=0. Then a=16'h1234, b=16'h1234, b_in=1 -> diff=16'hFFFF, b_out=1.
4. start held high continuously for 40 cycles with operands changing every cycle:
   - Only the IDLE-edge operands are used.
   - Accepts occur every 18 cycles; done pulses are exactly one cycle wide.
5. rst asserted when cnt=7 during a=16'hAAAA, b=16'h5555 -> next cycle diff=0, b_out=0, busy=0, done=0, no done pulse. A fresh start then yields diff=16'h5555, b_out=0.
6. Sweep with operands incrementing per operation (a+=1 each op, b+=1 every second op, b_in toggling):
   - 50 operations compared against the model {b_out,diff} = {1'b0,a} - b - b_in.
   - diff/b_out must be stable whenever busy=1.
